// File: rtl/test_monitor.sv
// Bus-side result monitor: snoops CPU writes to a result mailbox and latches a pass/fail/timeout verdict.
// Optional status readback ports at RESULT_ADDR+1 are enabled by defining TEST_MONITOR_READBACK_EN.
module test_monitor #(
    parameter logic [15:0] RESULT_ADDR = 16'h0042,
    parameter logic [7:0]  PASS_VALUE  = 8'hCF,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             ph2,
    input  logic             reset_b,
    input  logic [15:0]      address,
    input  logic [7:0]       data,
    input  logic             memwrite,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       result,
    output logic [CNT_W-1:0] cycles,
    output logic [7:0]       writes
`ifdef TEST_MONITOR_READBACK_EN
    ,
    output logic [7:0]       rdata,
    output logic             hit
`endif
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RUN  = 3'd1;
    localparam logic [2:0] PASS = 3'd2;
    localparam logic [2:0] FAIL = 3'd3;
    localparam logic [2:0] TOUT = 3'd4;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [7:0]       writes_q, writes_d;
    logic [7:0]       result_q, result_d;
    logic             mbox_hit;

    // Full 16-bit compare; aliases such as RESULT_ADDR^16'h0100 must not hit.
    assign mbox_hit = memwrite && (address == RESULT_ADDR);

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        writes_d = writes_q;
        result_d = result_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                cycles_d = cycles_q + CNT_W'(1);
                if (memwrite && (writes_q != 8'hFF)) begin
                    writes_d = writes_q + 8'd1;
                end
                // A mailbox write on the expiry edge takes priority over the timeout.
                if (mbox_hit) begin
                    result_d = data;
                    state_d  = (data == PASS_VALUE) ? PASS : FAIL;
                end else if (cycles_q == LAST_CYCLE) begin
                    state_d = TOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ph2 or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            cycles_q <= '0;
            writes_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            writes_q <= writes_d;
            result_q <= result_d;
        end
    end

    assign done    = (state_q == PASS) || (state_q == FAIL) || (state_q == TOUT);
    assign pass    = (state_q == PASS);
    assign timeout = (state_q == TOUT);
    assign result  = result_q;
    assign cycles  = cycles_q;
    assign writes  = writes_q;

`ifdef TEST_MONITOR_READBACK_EN
    assign hit   = reset_b && (address == RESULT_ADDR + 16'd1) && !memwrite;
    assign rdata = hit ? {done, pass, timeout, 5'b0} : 8'h00;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Directed self-checking bench for test_monitor: default budget instance plus a TIMEOUT=16 instance.
// Readback checks are compiled in when TEST_MONITOR_READBACK_EN is defined.
module tb_test_monitor;

    logic        ph2 = 1'b0;
    logic        reset_b, rst16;
    logic [15:0] address, a16;
    logic [7:0]  data, d16;
    logic        memwrite, w16;

    logic        done, pass, timeout;
    logic [7:0]  result, writes;
    logic [15:0] cycles;
    logic        done16, pass16, tout16;
    logic [7:0]  result16, writes16;
    logic [15:0] cycles16;
`ifdef TEST_MONITOR_READBACK_EN
    logic [7:0]  rdata, rdata16;
    logic        hit, hit16;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ph2 = ~ph2;

    test_monitor dut (
        .ph2      (ph2),
        .reset_b  (reset_b),
        .address  (address),
        .data     (data),
        .memwrite (memwrite),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .result   (result),
        .cycles   (cycles),
        .writes   (writes)
`ifdef TEST_MONITOR_READBACK_EN
        ,
        .rdata    (rdata),
        .hit      (hit)
`endif
    );

    test_monitor #(.TIMEOUT(16)) dut16 (
        .ph2      (ph2),
        .reset_b  (rst16),
        .address  (a16),
        .data     (d16),
        .memwrite (w16),
        .done     (done16),
        .pass     (pass16),
        .timeout  (tout16),
        .result   (result16),
        .cycles   (cycles16),
        .writes   (writes16)
`ifdef TEST_MONITOR_READBACK_EN
        ,
        .rdata    (rdata16),
        .hit      (hit16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ph2);
            #1;
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w);
        address  = a;
        data     = d;
        memwrite = w;
    endtask

    task automatic restart;
        reset_b = 1'b0;
        bus(16'h0000, 8'h00, 1'b0);
        #3;
        reset_b = 1'b1;
        step(1);  // edge 0: IDLE -> RUN
    endtask

    initial begin
        reset_b = 1'b0;
        rst16   = 1'b0;
        bus(16'h0000, 8'h00, 1'b0);
        a16 = 16'h0000;
        d16 = 8'h00;
        w16 = 1'b0;
        #12;
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_result", result, 0);
        check("rst_cycles", cycles, 0);
        check("rst_writes", writes, 0);

        // Pass: mailbox write sampled on edge 20.
        reset_b = 1'b1;
        step(1);
        check("idle_cycles", cycles, 0);
        step(19);
        check("run_cycles19", cycles, 19);
        check("run_not_done", done, 0);
`ifdef TEST_MONITOR_READBACK_EN
        bus(16'h0043, 8'h00, 1'b0);
        #1;
        check("rb_run_rdata", rdata, 8'h00);
        check("rb_run_hit", hit, 1);
`endif
        bus(16'h0042, 8'hCF, 1'b1);
        step(1);
        bus(16'h0000, 8'h00, 1'b0);
        check("pass_done", done, 1);
        check("pass_pass", pass, 1);
        check("pass_result", result, 8'hCF);
        check("pass_cycles", cycles, 20);
        check("pass_writes", writes, 1);
        check("pass_timeout", timeout, 0);
        step(50);
        check("pass_frozen", cycles, 20);
        check("pass_hold", pass, 1);
`ifdef TEST_MONITOR_READBACK_EN
        bus(16'h0043, 8'h00, 1'b0);
        #1;
        check("rb_pass_rdata", rdata, 8'hC0);
        bus(16'h0042, 8'h00, 1'b0);
        #1;
        check("rb_nohit", hit, 0);
`endif

        // Fail, then a later pass write is ignored.
        restart();
        step(3);
        bus(16'h0042, 8'h3A, 1'b1);
        step(1);
        bus(16'h0042, 8'hCF, 1'b1);
        step(1);
        bus(16'h0000, 8'h00, 1'b0);
        check("fail_done", done, 1);
        check("fail_pass", pass, 0);
        check("fail_result", result, 8'h3A);
        check("fail_writes", writes, 1);
        check("fail_cycles", cycles, 4);

        // Near-miss alias, then write saturation.
        restart();
        bus(16'h0142, 8'hCF, 1'b1);
        step(1);
        check("alias_done", done, 0);
        check("alias_writes", writes, 1);
        bus(16'h0200, 8'h55, 1'b1);
        step(299);
        bus(16'h0000, 8'h00, 1'b0);
        check("sat_writes", writes, 255);
        check("sat_cycles", cycles, 300);
        check("sat_done", done, 0);

        // Asynchronous reset mid-cycle.
        #2;
        reset_b = 1'b0;
        #1;
        check("arst_cycles", cycles, 0);
        check("arst_writes", writes, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        reset_b = 1'b1;
        @(posedge ph2);
        #1;
        bus(16'h0042, 8'hCF, 1'b1);
        step(1);
        bus(16'h0000, 8'h00, 1'b0);
        check("rerun_pass", pass, 1);
        check("rerun_cycles", cycles, 1);

        // Timeout with TIMEOUT=16.
        #3;
        rst16 = 1'b1;
        step(1);
        step(15);
        check("to_before", tout16, 0);
        check("to_cycles15", cycles16, 15);
        step(1);
        check("to_timeout", tout16, 1);
        check("to_cycles", cycles16, 16);
        check("to_result", result16, 0);
        check("to_done", done16, 1);
        step(5);
        check("to_frozen", cycles16, 16);

        // Mailbox write on the expiry edge wins.
        rst16 = 1'b0;
        #3;
        rst16 = 1'b1;
        step(1);
        step(15);
        a16 = 16'h0042;
        d16 = 8'hCF;
        w16 = 1'b1;
        step(1);
        w16 = 1'b0;
        check("tie_pass", pass16, 1);
        check("tie_timeout", tout16, 0);
        check("tie_cycles", cycles16, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
